// File: rtl/chimera_pkg.sv
// Shared Chimera cluster-domain types: power-sequencer state and the
// per-state control decode used by the sequencer and the status registers.
package chimera_pkg;

   typedef enum logic [2:0] {
      CLU_OFF    = 3'd0,
      CLU_UP_CLK = 3'd1,
      CLU_UP_ISO = 3'd2,
      CLU_ON     = 3'd3,
      CLU_DN_ISO = 3'd4,
      CLU_DN_RST = 3'd5
   } clu_pwr_state_e;

   typedef struct packed {
      logic iso_en;
      logic clk_gate_en;
      logic rst_n;
   } clu_pwr_ctl_t;

   // Control levels seen by the cluster for each sequencer state.
   function automatic clu_pwr_ctl_t clu_pwr_decode(input clu_pwr_state_e state);
      clu_pwr_ctl_t ctl;
      ctl = '{iso_en: 1'b1, clk_gate_en: 1'b1, rst_n: 1'b0};
      case (state)
         CLU_OFF:    ctl = '{iso_en: 1'b1, clk_gate_en: 1'b1, rst_n: 1'b0};
         CLU_UP_CLK: ctl = '{iso_en: 1'b1, clk_gate_en: 1'b0, rst_n: 1'b0};
         CLU_UP_ISO: ctl = '{iso_en: 1'b0, clk_gate_en: 1'b0, rst_n: 1'b1};
         CLU_ON:     ctl = '{iso_en: 1'b0, clk_gate_en: 1'b0, rst_n: 1'b1};
         CLU_DN_ISO: ctl = '{iso_en: 1'b1, clk_gate_en: 1'b0, rst_n: 1'b1};
         CLU_DN_RST: ctl = '{iso_en: 1'b1, clk_gate_en: 1'b0, rst_n: 1'b0};
         default:    ctl = '{iso_en: 1'b1, clk_gate_en: 1'b1, rst_n: 1'b0};
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// Single-cluster power sequencer: walks the cluster through clock ungate,
// reset, isolation release (and the reverse) with bounded ack waits.
module chimera_clu_pwr_fsm
   import chimera_pkg::*;
#(
   parameter int unsigned RstCycles  = 8,
   parameter int unsigned AckTimeout = 255
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           on_req_i,
   input  logic           grant_i,
   input  logic           err_clr_i,
   input  logic           iso_ack_i,
   output clu_pwr_state_e state_o,
   output logic           iso_en_o,
   output logic           clk_gate_en_o,
   output logic           rst_no,
   output logic           on_o,
   output logic           busy_o,
   output logic           up_busy_o,
   output logic           up_done_o,
   output logic           timeout_err_o
);

   localparam int unsigned RstW = $clog2(RstCycles + 1);
   localparam int unsigned AckW = $clog2(AckTimeout + 1);
   localparam logic [RstW-1:0] RstLast = RstW'(RstCycles - 1);
   localparam logic [RstW-1:0] RstMax  = RstW'(RstCycles);
   localparam logic [AckW-1:0] AckLast = AckW'(AckTimeout - 1);
   localparam logic [AckW-1:0] AckMax  = AckW'(AckTimeout);

   clu_pwr_state_e  state_q, state_d;
   logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
   logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
   logic            err_q, err_d;
   logic            err_set;
   logic            rst_done;
   logic            ack_expire;
   clu_pwr_ctl_t    ctl;

   assign rst_done   = (rst_cnt_q >= RstLast);
   assign ack_expire = (ack_cnt_q >= AckLast);

   // Next-state selection; request changes are only looked at in OFF and ON.
   always_comb begin
      state_d   = state_q;
      err_set   = 1'b0;
      up_done_o = 1'b0;
      case (state_q)
         CLU_OFF: begin
            if (on_req_i && grant_i) state_d = CLU_UP_CLK;
         end
         CLU_UP_CLK: begin
            if (rst_done) state_d = CLU_UP_ISO;
         end
         CLU_UP_ISO: begin
            if (!iso_ack_i) begin
               state_d   = CLU_ON;
               up_done_o = 1'b1;
            end else if (ack_expire) begin
               state_d   = CLU_ON;
               up_done_o = 1'b1;
               err_set   = 1'b1;
            end
         end
         CLU_ON: begin
            if (!on_req_i) state_d = CLU_DN_ISO;
         end
         CLU_DN_ISO: begin
            if (iso_ack_i) begin
               state_d = CLU_DN_RST;
            end else if (ack_expire) begin
               state_d = CLU_DN_RST;
               err_set = 1'b1;
            end
         end
         CLU_DN_RST: begin
            if (rst_done) state_d = CLU_OFF;
         end
         default: state_d = CLU_OFF;
      endcase
   end

   // Both counters restart on every state change and saturate while waiting.
   always_comb begin
      rst_cnt_d = rst_cnt_q;
      ack_cnt_d = ack_cnt_q;
      if (state_d != state_q) begin
         rst_cnt_d = '0;
         ack_cnt_d = '0;
      end else begin
         if ((state_q == CLU_UP_CLK || state_q == CLU_DN_RST) && rst_cnt_q != RstMax)
            rst_cnt_d = rst_cnt_q + 1'b1;
         if ((state_q == CLU_UP_ISO || state_q == CLU_DN_ISO) && ack_cnt_q != AckMax)
            ack_cnt_d = ack_cnt_q + 1'b1;
      end
   end

   // Sticky timeout flag: a new timeout beats a simultaneous clear.
   always_comb begin
      err_d = err_q;
      if (err_set)        err_d = 1'b1;
      else if (err_clr_i) err_d = 1'b0;
   end

   // State, counters and error flag registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= CLU_OFF;
         rst_cnt_q <= '0;
         ack_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         ack_cnt_q <= ack_cnt_d;
         err_q     <= err_d;
      end
   end

   assign ctl           = clu_pwr_decode(state_q);
   assign state_o       = state_q;
   assign iso_en_o      = ctl.iso_en;
   assign clk_gate_en_o = ctl.clk_gate_en;
   assign rst_no        = ctl.rst_n;
   assign on_o          = (state_q == CLU_ON);
   assign busy_o        = (state_q != CLU_OFF) && (state_q != CLU_ON);
   assign up_busy_o     = (state_q == CLU_UP_CLK) || (state_q == CLU_UP_ISO);
   assign timeout_err_o = err_q;

endmodule

// File: rtl/chimera_clu_pwr_ctrl.sv
// Chimera cluster power controller: one sequencer per cluster plus a
// round-robin scheduler that admits one power-up at a time.
module chimera_clu_pwr_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned NumClusters = 5,
   parameter int unsigned RstCycles   = 8,
   parameter int unsigned AckTimeout  = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] on_req_i,
   input  logic [NumClusters-1:0] err_clr_i,
   input  logic [NumClusters-1:0] clu_iso_ack_i,
   output logic [NumClusters-1:0] clu_iso_en_o,
   output logic [NumClusters-1:0] clu_clk_gate_en_o,
   output logic [NumClusters-1:0] clu_rst_no,
   output logic [NumClusters-1:0] on_o,
   output logic [NumClusters-1:0] busy_o,
   output logic [NumClusters-1:0] timeout_err_o
);

   localparam int unsigned PtrW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

   clu_pwr_state_e         state [NumClusters];
   logic [NumClusters-1:0] is_off;
   logic [NumClusters-1:0] up_busy;
   logic [NumClusters-1:0] up_done;
   logic [NumClusters-1:0] grant;
   logic                   up_free;
   logic                   grant_vld;
   logic [PtrW-1:0]        grant_idx;
   logic [PtrW-1:0]        ptr_q, ptr_d;

   // A power-up slot is free when nobody is powering up, or when the current
   // owner leaves UP_ISO this cycle so the next cluster can start on the same edge.
   assign up_free = ~|up_busy || |up_done;

   // Round-robin search from ptr for the first idle cluster requesting power.
   always_comb begin
      logic [PtrW-1:0] sel;
      grant     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      sel       = '0;
      if (up_free) begin
         for (int unsigned k = 0; k < NumClusters; k++) begin
            if (32'(ptr_q) + k >= NumClusters) sel = PtrW'(32'(ptr_q) + k - NumClusters);
            else                               sel = PtrW'(32'(ptr_q) + k);
            if (!grant_vld && is_off[sel] && on_req_i[sel]) begin
               grant_vld  = 1'b1;
               grant[sel] = 1'b1;
               grant_idx  = sel;
            end
         end
      end
      ptr_d = ptr_q;
      if (grant_vld)
         ptr_d = (grant_idx == PtrW'(NumClusters - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   for (genvar i = 0; i < NumClusters; i++) begin : g_clu
      chimera_clu_pwr_fsm #(
         .RstCycles (RstCycles),
         .AckTimeout(AckTimeout)
      ) u_fsm (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .on_req_i     (on_req_i[i]),
         .grant_i      (grant[i]),
         .err_clr_i    (err_clr_i[i]),
         .iso_ack_i    (clu_iso_ack_i[i]),
         .state_o      (state[i]),
         .iso_en_o     (clu_iso_en_o[i]),
         .clk_gate_en_o(clu_clk_gate_en_o[i]),
         .rst_no       (clu_rst_no[i]),
         .on_o         (on_o[i]),
         .busy_o       (busy_o[i]),
         .up_busy_o    (up_busy[i]),
         .up_done_o    (up_done[i]),
         .timeout_err_o(timeout_err_o[i])
      );
      assign is_off[i] = (state[i] == CLU_OFF);
   end

endmodule

// File: tb/tb_chimera_clu_pwr_ctrl.sv
// Bench for chimera_clu_pwr_ctrl: phase-timer reference model checked every
// cycle, directed scenarios with hand-computed timings, then random traffic.
module tb_chimera_clu_pwr_ctrl;

   localparam int N = 5;
   localparam int R = 8;
   localparam int T = 255;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] on_req  = '0;
   logic [N-1:0] err_clr = '0;
   logic [N-1:0] ack     = '1;
   logic [N-1:0] iso_en, gate_en, rst_n, on, busy, err;

   chimera_clu_pwr_ctrl #(
      .NumClusters(N),
      .RstCycles  (R),
      .AckTimeout (T)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .on_req_i         (on_req),
      .err_clr_i        (err_clr),
      .clu_iso_ack_i    (ack),
      .clu_iso_en_o     (iso_en),
      .clu_clk_gate_en_o(gate_en),
      .clu_rst_no       (rst_n),
      .on_o             (on),
      .busy_o           (busy),
      .timeout_err_o    (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: mode 0=off 1=powering up 2=on 3=powering down
   int m_mode [N];
   int m_t    [N];   // cycles spent in the reset-with-clock phase
   int m_w    [N];   // cycles spent waiting for the ack
   bit m_dw   [N];   // powering down and still waiting for the ack
   bit m_err  [N];
   int m_ptr;

   // cluster-side ack behaviour
   bit [N-1:0] ack_stuck = '0;
   int         ack_delay [N];
   int         ack_cnt   [N];
   bit         rand_ack  = 1'b0;

   int         busy_rise [N];
   int         on_rise   [N];
   logic [N-1:0] prev_busy = '0;
   logic [N-1:0] prev_on   = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mode[i] = 0; m_t[i] = 0; m_w[i] = 0; m_dw[i] = 0; m_err[i] = 0;
      end
      m_ptr = 0;
   endtask

   task automatic model_step();
      bit up_busy, up_leave, set_e;
      int g, j;
      up_busy = 0; up_leave = 0; g = -1;
      for (int i = 0; i < N; i++) begin
         if (m_mode[i] == 1) begin
            up_busy = 1;
            if (m_t[i] >= R && (!ack[i] || m_w[i] + 1 == T)) up_leave = 1;
         end
      end
      if (!up_busy || up_leave) begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && m_mode[j] == 0 && on_req[j]) g = j;
         end
      end
      for (int i = 0; i < N; i++) begin
         set_e = 0;
         case (m_mode[i])
            0: if (i == g) begin m_mode[i] = 1; m_t[i] = 0; m_w[i] = 0; end
            1: begin
               if (m_t[i] < R) m_t[i]++;
               else begin
                  m_w[i]++;
                  if (!ack[i]) m_mode[i] = 2;
                  else if (m_w[i] == T) begin m_mode[i] = 2; set_e = 1; end
               end
            end
            2: if (!on_req[i]) begin m_mode[i] = 3; m_dw[i] = 1; m_w[i] = 0; m_t[i] = 0; end
            3: begin
               if (m_dw[i]) begin
                  m_w[i]++;
                  if (ack[i]) m_dw[i] = 0;
                  else if (m_w[i] == T) begin m_dw[i] = 0; set_e = 1; end
               end else begin
                  m_t[i]++;
                  if (m_t[i] == R) m_mode[i] = 0;
               end
            end
            default: m_mode[i] = 0;
         endcase
         if (set_e) m_err[i] = 1;
         else if (err_clr[i]) m_err[i] = 0;
      end
      if (g >= 0) m_ptr = (g + 1) % N;
   endtask

   task automatic compare_all();
      logic [N-1:0] e_iso, e_gate, e_rst, e_on, e_busy, e_err;
      for (int i = 0; i < N; i++) begin
         e_iso[i] = 1'b1; e_gate[i] = 1'b1; e_rst[i] = 1'b0;
         case (m_mode[i])
            1: begin e_gate[i] = 1'b0; e_iso[i] = (m_t[i] < R); e_rst[i] = (m_t[i] >= R); end
            2: begin e_gate[i] = 1'b0; e_iso[i] = 1'b0; e_rst[i] = 1'b1; end
            3: begin e_gate[i] = 1'b0; e_iso[i] = 1'b1; e_rst[i] = m_dw[i]; end
            default: ;
         endcase
         e_on[i]   = (m_mode[i] == 2);
         e_busy[i] = (m_mode[i] == 1) || (m_mode[i] == 3);
         e_err[i]  = m_err[i];
      end
      chk("iso_en",   32'(iso_en),  32'(e_iso));
      chk("gate_en",  32'(gate_en), 32'(e_gate));
      chk("rst_n",    32'(rst_n),   32'(e_rst));
      chk("on",       32'(on),      32'(e_on));
      chk("busy",     32'(busy),    32'(e_busy));
      chk("timeout",  32'(err),     32'(e_err));
   endtask

   task automatic clear_rises();
      for (int i = 0; i < N; i++) begin busy_rise[i] = -1; on_rise[i] = -1; end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_delay(input int d);
      for (int i = 0; i < N; i++) ack_delay[i] = d;
   endtask

   task automatic wait_on(input int i, input int budget);
      int n;
      n = 0;
      while (!on[i] && n < budget) begin @(negedge clk); n++; end
      if (!on[i]) chk("wait_on", 32'(on[i]), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      on_req = '0; err_clr = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_iso",  32'(iso_en),  32'h1f);
      chk("rst_gate", 32'(gate_en), 32'h1f);
      chk("rst_rstn", 32'(rst_n),   32'h0);
      chk("rst_on",   32'(on | busy | err), 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (4) step();
   endtask

   // model tracks the DUT clock edges and the asynchronous reset
   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // per-cycle check against the model, plus rise-time capture
   initial begin
      clear_rises();
      forever begin
         @(negedge clk);
         compare_all();
         for (int i = 0; i < N; i++) begin
            if (busy[i] && !prev_busy[i] && busy_rise[i] < 0) busy_rise[i] = cyc;
            if (on[i] && !prev_on[i] && on_rise[i] < 0) on_rise[i] = cyc;
         end
         prev_busy = busy;
         prev_on   = on;
      end
   end

   // cluster domain: ack follows iso_en after a per-cluster delay
   initial begin
      for (int i = 0; i < N; i++) begin ack_delay[i] = 1; ack_cnt[i] = 0; end
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (ack_stuck[i]) ack_cnt[i] = 0;
            else if (ack[i] != iso_en[i]) begin
               ack_cnt[i]++;
               if (ack_cnt[i] >= ack_delay[i]) begin
                  ack[i] = iso_en[i];
                  ack_cnt[i] = 0;
                  if (rand_ack) ack_delay[i] = $urandom_range(1, 4);
               end
            end else ack_cnt[i] = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, c0, dn, oncnt;
      bit seen_on;

      // --- single cluster power-up, ack drops 2 cycles after iso release
      set_delay(2);
      do_reset();
      on_req = 5'b00001;
      k = 0;
      do begin
         @(posedge clk); k++; #1;
         if (k == 1)  chk("t1_upclk", 32'({iso_en[0], gate_en[0], rst_n[0]}), 32'b100);
         if (k == 10) chk("t1_upiso", 32'({iso_en[0], gate_en[0], rst_n[0]}), 32'b001);
      end while (!on[0] && k < 100);
      chk("t1_latency", k, 11);
      chk("t1_others", 32'(busy[4:1] | on[4:1]), 32'h0);
      chk("t1_others_gate", 32'(gate_en[4:1]), 32'hf);

      // --- all request at once: strictly serial, back-to-back grants
      set_delay(1);
      do_reset();
      clear_rises();
      on_req = '1;
      c0 = cyc;
      wait_on(4, 300);
      for (int i = 0; i < N; i++) begin
         chk("t2_busy_rise", busy_rise[i], c0 + 1 + 9 * i);
         chk("t2_on_rise",   on_rise[i],   c0 + 10 + 9 * i);
      end

      // --- after cluster 2 served, 0 and 4 together: 4 goes first
      do_reset();
      on_req = 5'b00100;
      wait_on(2, 100);
      step();
      clear_rises();
      on_req = 5'b10101;
      c0 = cyc;
      wait_on(0, 100);
      chk("t3_first4", busy_rise[4], c0 + 1);
      chk("t3_then0",  busy_rise[0], c0 + 10);

      // --- request dropped during UP_CLK: completes, then powers down
      do_reset();
      on_req = 5'b00001;
      c0 = cyc;
      repeat (3) step();
      on_req = '0;
      oncnt = 0; seen_on = 0; k = 0;
      while (k < 100) begin
         @(negedge clk); k++;
         if (on[0]) begin oncnt++; seen_on = 1; end
         if (seen_on && !on[0] && !busy[0]) break;
      end
      chk("t5_on_cycles", oncnt, 1);
      chk("t5_off_cycle", cyc, c0 + 20);
      chk("t5_off_ctl", 32'({iso_en[0], gate_en[0], rst_n[0]}), 32'b110);

      // --- async reset while in UP_ISO
      do_reset();
      ack_delay[0] = 3;
      on_req = 5'b00001;
      k = 0;
      while (iso_en[0] && k < 50) begin @(posedge clk); #1; k++; end
      chk("t6_in_upiso", 32'({iso_en[0], gate_en[0], rst_n[0]}), 32'b001);
      #2 rst = 1'b1;
      on_req = '0;
      #1;
      chk("t6_async_iso",  32'(iso_en),  32'h1f);
      chk("t6_async_gate", 32'(gate_en), 32'h1f);
      chk("t6_async_rstn", 32'(rst_n),   32'h0);
      chk("t6_async_busy", 32'(busy | on), 32'h0);
      @(negedge clk);
      chk("t6_hold_gate", 32'(gate_en), 32'h1f);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_after_gate", 32'(gate_en), 32'h1f);
      set_delay(1);
      repeat (4) step();

      // --- power-down with ack never rising: timeout, sticky flag, clear
      on_req = 5'b00010;
      wait_on(1, 100);
      step();
      ack_stuck[1] = 1'b1;
      on_req = '0;
      dn = 0; k = 0;
      while (k < 400) begin
         @(negedge clk); k++;
         if (iso_en[1] && rst_n[1]) dn++;
         else if (dn > 0) break;
      end
      chk("t4_dniso_len", dn, 255);
      chk("t4_err_set", 32'(err[1]), 32'd1);
      repeat (12) step();
      chk("t4_err_hold", 32'(err[1]), 32'd1);
      err_clr = 5'b00010;
      step();
      err_clr = '0;
      chk("t4_err_clr", 32'(err[1]), 32'd0);
      ack_stuck[1] = 1'b0;
      repeat (3) step();
      on_req = 5'b00010;
      wait_on(1, 100);
      step();
      ack_stuck[1] = 1'b1;
      on_req = '0;
      @(posedge clk);
      repeat (254) @(posedge clk);
      #2 err_clr = 5'b00010;
      @(posedge clk);
      #2 err_clr = '0;
      chk("t4_set_beats_clr", 32'(err[1]), 32'd1);
      chk("t4_dnrst", 32'({iso_en[1], gate_en[1], rst_n[1]}), 32'b100);
      ack_stuck[1] = 1'b0;
      repeat (12) step();

      // --- random traffic against the model
      rand_ack = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) on_req[i] = ~on_req[i];
            err_clr[i] = ($urandom_range(0, 7) == 0);
         end
         if (n == 1500) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
      end
      err_clr = '0;
      on_req  = '0;
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
